// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, ALU
// selects, state encoding, opcode classes and the control-line bundle.
package control_sequencer_pkg;

  localparam int OPW  = 5;
  localparam int ALUW = 4;

  // Opcodes found in IR[31:27]
  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPW-1:0] OP_BR   = 5'b10010;
  localparam logic [OPW-1:0] OP_JR   = 5'b10100;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  // ALU operation selects
  localparam logic [ALUW-1:0] ALU_ADD = 4'd0;
  localparam logic [ALUW-1:0] ALU_SUB = 4'd1;
  localparam logic [ALUW-1:0] ALU_AND = 4'd2;
  localparam logic [ALUW-1:0] ALU_OR  = 4'd3;

  // Sequencer states; RST is only occupied while reset is held
  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_T7   = 4'd8,
    ST_HALT = 4'd9
  } state_e;

  // Bit positions of the one-hot opcode class vector
  localparam int NCLASS     = 10;
  localparam int CL_ALU_RR  = 0;
  localparam int CL_ALU_IMM = 1;
  localparam int CL_LDI     = 2;
  localparam int CL_LD      = 3;
  localparam int CL_ST      = 4;
  localparam int CL_BR      = 5;
  localparam int CL_JR      = 6;
  localparam int CL_NOP     = 7;
  localparam int CL_HALT    = 8;
  localparam int CL_BAD     = 9;

  // Every control line the sequencer can drive in one cycle
  typedef struct packed {
    logic            gra;
    logic            grb;
    logic            grc;
    logic            rin;
    logic            rout;
    logic            baout;
    logic            cout;
    logic            pcout;
    logic            mdrout;
    logic            zlowout;
    logic            pcin;
    logic            irin;
    logic            marin;
    logic            mdrin;
    logic            yin;
    logic            zin;
    logic            conin;
    logic            incpc;
    logic            read;
    logic            write;
    logic            run;
    logic            illegal;
    logic [ALUW-1:0] alu_op;
  } ctrl_t;

  // ALU select for register/immediate arithmetic opcodes
  function automatic logic [ALUW-1:0] alu_sel(input logic [OPW-1:0] op);
    case (op)
      OP_SUB:          alu_sel = ALU_SUB;
      OP_AND, OP_ANDI: alu_sel = ALU_AND;
      OP_OR,  OP_ORI:  alu_sel = ALU_OR;
      default:         alu_sel = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_opcode_class.sv
// Combinational opcode classifier: maps IR[31:27] to a one-hot class vector
// so the sequencer reasons about instruction families, not raw opcodes.
module opcode_class
  import control_sequencer_pkg::*;
(
  input  logic [OPW-1:0]    i_opcode,
  output logic [NCLASS-1:0] o_class
);

  // One-hot class decode; anything unlisted is flagged as bad
  always_comb begin
    o_class = '0;
    case (i_opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: o_class[CL_ALU_RR]  = 1'b1;
      OP_ADDI, OP_ANDI, OP_ORI:      o_class[CL_ALU_IMM] = 1'b1;
      OP_LDI:                        o_class[CL_LDI]     = 1'b1;
      OP_LD:                         o_class[CL_LD]      = 1'b1;
      OP_ST:                         o_class[CL_ST]      = 1'b1;
      OP_BR:                         o_class[CL_BR]      = 1'b1;
      OP_JR:                         o_class[CL_JR]      = 1'b1;
      OP_NOP:                        o_class[CL_NOP]     = 1'b1;
      OP_HALT:                       o_class[CL_HALT]    = 1'b1;
      default:                       o_class[CL_BAD]     = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit. Only the step state is registered; every
// control line is decoded from the state and the current IR opcode. Fetch
// is T0-T2, execute T3-T7, and each instruction returns to T0 (or HALT when
// stop is high on the edge that would enter T0).
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic            clock,
  input  logic            reset_n,
  input  logic [31:0]     ir,
  input  logic            con_ff,
  input  logic            stop,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic            BAout,
  output logic            Cout,
  output logic            PCout,
  output logic            MDRout,
  output logic            Zlowout,
  output logic            PCin,
  output logic            IRin,
  output logic            MARin,
  output logic            MDRin,
  output logic            Yin,
  output logic            Zin,
  output logic            CONin,
  output logic            IncPC,
  output logic            Read,
  output logic            Write,
  output logic [ALUW-1:0] alu_op,
  output logic            run,
  output logic            illegal,
  output logic [3:0]      o_state
);

  state_e            r_state;
  state_e            w_end_state;
  logic [NCLASS-1:0] w_cls;
  logic [OPW-1:0]    w_opcode;
  logic              w_multi_cycle_mem;
  ctrl_t             w_ctrl;
  logic              w_unused_ir;

  assign w_opcode    = ir[31:27];
  assign w_unused_ir = ^ir[26:0];

  opcode_class u_opcode_class (
    .i_opcode (w_opcode),
    .o_class  (w_cls)
  );

  // Where an instruction goes when it finishes: stop diverts to HALT
  assign w_end_state = stop ? ST_HALT : ST_T0;

  // ld, st and br run past T5
  assign w_multi_cycle_mem = w_cls[CL_LD] | w_cls[CL_ST] | w_cls[CL_BR];

  // Step register and next-step selection
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RST;
    end else begin
      case (r_state)
        ST_RST:  r_state <= w_end_state;
        ST_T0:   r_state <= ST_T1;
        ST_T1:   r_state <= ST_T2;
        ST_T2:   r_state <= ST_T3;
        ST_T3: begin
          if (w_cls[CL_HALT])
            r_state <= ST_HALT;
          else if (w_cls[CL_JR] | w_cls[CL_NOP] | w_cls[CL_BAD])
            r_state <= w_end_state;
          else
            r_state <= ST_T4;
        end
        ST_T4:   r_state <= ST_T5;
        ST_T5:   r_state <= w_multi_cycle_mem ? ST_T6 : w_end_state;
        ST_T6:   r_state <= (w_cls[CL_LD] | w_cls[CL_ST]) ? ST_T7 : w_end_state;
        ST_T7:   r_state <= w_end_state;
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_RST;
      endcase
    end
  end

  // Control-line decode from the current step and opcode class
  always_comb begin
    w_ctrl = '0;
    case (r_state)
      ST_T0: begin
        w_ctrl.run   = 1'b1;
        w_ctrl.pcout = 1'b1;
        w_ctrl.marin = 1'b1;
        w_ctrl.incpc = 1'b1;
        w_ctrl.zin   = 1'b1;
      end
      ST_T1: begin
        w_ctrl.run     = 1'b1;
        w_ctrl.zlowout = 1'b1;
        w_ctrl.pcin    = 1'b1;
        w_ctrl.read    = 1'b1;
        w_ctrl.mdrin   = 1'b1;
      end
      ST_T2: begin
        w_ctrl.run    = 1'b1;
        w_ctrl.mdrout = 1'b1;
        w_ctrl.irin   = 1'b1;
      end
      ST_T3: begin
        w_ctrl.run = 1'b1;
        if (w_cls[CL_ALU_RR] | w_cls[CL_ALU_IMM]) begin
          w_ctrl.grb  = 1'b1;
          w_ctrl.rout = 1'b1;
          w_ctrl.yin  = 1'b1;
        end else if (w_cls[CL_LDI] | w_cls[CL_LD] | w_cls[CL_ST]) begin
          w_ctrl.grb   = 1'b1;
          w_ctrl.baout = 1'b1;
          w_ctrl.yin   = 1'b1;
        end else if (w_cls[CL_BR]) begin
          w_ctrl.gra   = 1'b1;
          w_ctrl.rout  = 1'b1;
          w_ctrl.conin = 1'b1;
        end else if (w_cls[CL_JR]) begin
          w_ctrl.gra  = 1'b1;
          w_ctrl.rout = 1'b1;
          w_ctrl.pcin = 1'b1;
        end else if (w_cls[CL_BAD]) begin
          w_ctrl.illegal = 1'b1;
        end
      end
      ST_T4: begin
        w_ctrl.run = 1'b1;
        if (w_cls[CL_ALU_RR]) begin
          w_ctrl.grc    = 1'b1;
          w_ctrl.rout   = 1'b1;
          w_ctrl.zin    = 1'b1;
          w_ctrl.alu_op = alu_sel(w_opcode);
        end else if (w_cls[CL_ALU_IMM]) begin
          w_ctrl.cout   = 1'b1;
          w_ctrl.zin    = 1'b1;
          w_ctrl.alu_op = alu_sel(w_opcode);
        end else if (w_cls[CL_LDI] | w_cls[CL_LD] | w_cls[CL_ST]) begin
          w_ctrl.cout   = 1'b1;
          w_ctrl.zin    = 1'b1;
          w_ctrl.alu_op = ALU_ADD;
        end else if (w_cls[CL_BR]) begin
          w_ctrl.pcout = 1'b1;
          w_ctrl.yin   = 1'b1;
        end
      end
      ST_T5: begin
        w_ctrl.run = 1'b1;
        if (w_cls[CL_ALU_RR] | w_cls[CL_ALU_IMM] | w_cls[CL_LDI]) begin
          w_ctrl.zlowout = 1'b1;
          w_ctrl.gra     = 1'b1;
          w_ctrl.rin     = 1'b1;
        end else if (w_cls[CL_LD] | w_cls[CL_ST]) begin
          w_ctrl.zlowout = 1'b1;
          w_ctrl.marin   = 1'b1;
        end else if (w_cls[CL_BR]) begin
          w_ctrl.cout   = 1'b1;
          w_ctrl.zin    = 1'b1;
          w_ctrl.alu_op = ALU_ADD;
        end
      end
      ST_T6: begin
        w_ctrl.run = 1'b1;
        if (w_cls[CL_LD]) begin
          w_ctrl.read  = 1'b1;
          w_ctrl.mdrin = 1'b1;
        end else if (w_cls[CL_ST]) begin
          // MDR loads the store data from the bus, so no memory read here
          w_ctrl.gra   = 1'b1;
          w_ctrl.rout  = 1'b1;
          w_ctrl.mdrin = 1'b1;
        end else if (w_cls[CL_BR]) begin
          w_ctrl.zlowout = 1'b1;
          w_ctrl.pcin    = con_ff;
        end
      end
      ST_T7: begin
        w_ctrl.run = 1'b1;
        if (w_cls[CL_LD]) begin
          w_ctrl.mdrout = 1'b1;
          w_ctrl.gra    = 1'b1;
          w_ctrl.rin    = 1'b1;
        end else if (w_cls[CL_ST]) begin
          w_ctrl.write = 1'b1;
        end
      end
      default: w_ctrl = '0;
    endcase
  end

  assign Gra     = w_ctrl.gra;
  assign Grb     = w_ctrl.grb;
  assign Grc     = w_ctrl.grc;
  assign Rin     = w_ctrl.rin;
  assign Rout    = w_ctrl.rout;
  assign BAout   = w_ctrl.baout;
  assign Cout    = w_ctrl.cout;
  assign PCout   = w_ctrl.pcout;
  assign MDRout  = w_ctrl.mdrout;
  assign Zlowout = w_ctrl.zlowout;
  assign PCin    = w_ctrl.pcin;
  assign IRin    = w_ctrl.irin;
  assign MARin   = w_ctrl.marin;
  assign MDRin   = w_ctrl.mdrin;
  assign Yin     = w_ctrl.yin;
  assign Zin     = w_ctrl.zin;
  assign CONin   = w_ctrl.conin;
  assign IncPC   = w_ctrl.incpc;
  assign Read    = w_ctrl.read;
  assign Write   = w_ctrl.write;
  assign alu_op  = w_ctrl.alu_op;
  assign run     = w_ctrl.run;
  assign illegal = w_ctrl.illegal;
  assign o_state = r_state;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer. The reference model turns each instruction
// into the list of per-cycle control words it must produce; a single
// negedge process pops and compares one word per cycle.
module tb_control_sequencer;
  import control_sequencer_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  bit          clock;
  logic        reset_n;
  logic [31:0] ir;
  logic        con_ff;
  logic        stop;
  logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout;
  logic        PCout, MDRout, Zlowout;
  logic        PCin, IRin, MARin, MDRin, Yin, Zin, CONin;
  logic        IncPC, Read, Write;
  logic [3:0]  alu_op;
  logic        run, illegal;
  logic [3:0]  o_state;

  always #5 clock = ~clock;

  control_sequencer dut (
    .clock(clock), .reset_n(reset_n), .ir(ir), .con_ff(con_ff), .stop(stop),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Cout(Cout), .PCout(PCout), .MDRout(MDRout), .Zlowout(Zlowout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin),
    .Zin(Zin), .CONin(CONin), .IncPC(IncPC), .Read(Read), .Write(Write),
    .alu_op(alu_op), .run(run), .illegal(illegal), .o_state(o_state)
  );

  // ---------------- control word layout ----------------
  localparam int W = 26;
  localparam int B_GRA = 0,  B_GRB = 1,  B_GRC = 2,  B_RIN = 3,  B_ROUT = 4;
  localparam int B_BAOUT = 5, B_COUT = 6, B_PCOUT = 7, B_MDROUT = 8;
  localparam int B_ZLOWOUT = 9, B_PCIN = 10, B_IRIN = 11, B_MARIN = 12;
  localparam int B_MDRIN = 13, B_YIN = 14, B_ZIN = 15, B_CONIN = 16;
  localparam int B_INCPC = 17, B_READ = 18, B_WRITE = 19, B_RUN = 20;
  localparam int B_ILLEGAL = 21;

  logic [W-1:0] dut_word;
  assign dut_word = {alu_op, illegal, run, Write, Read, IncPC, CONin, Zin, Yin,
                     MDRin, MARin, IRin, PCin, Zlowout, MDRout, PCout, Cout,
                     BAout, Rout, Rin, Grc, Grb, Gra};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  string        cur_tag = "reset";

  function automatic logic [W-1:0] m(input int b);
    logic [W-1:0] r;
    r    = '0;
    r[b] = 1'b1;
    return r;
  endfunction

  function automatic logic [W-1:0] alu_w(input int k);
    logic [W-1:0] r;
    r = W'(k) << 22;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One compare per cycle while the model has an expectation queued
  always @(negedge clock) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (dut_word !== e) begin
        n_err++;
        $display("FAIL %s ctrl_word: got %h expected %h (t=%0t)", cur_tag, dut_word, e, $time);
      end
    end
    n_cmp++;
    if (Read === 1'b1 && Write === 1'b1) begin
      n_err++;
      $display("FAIL %s read_write_overlap: got Read=1 Write=1 required not both", cur_tag);
    end
  end

  // ---------------- reference model ----------------
  task automatic push_run(input logic [W-1:0] w, inout int len);
    exp_q.push_back(w | m(B_RUN));
    len++;
  endtask

  // Expected control words from T0 to the instruction's last step
  task automatic model_instr(input logic [31:0] instr, input logic con, output int len);
    logic [4:0] op;
    int         aop;
    op  = instr[31:27];
    len = 0;
    push_run(m(B_PCOUT) | m(B_MARIN) | m(B_INCPC) | m(B_ZIN), len);
    push_run(m(B_ZLOWOUT) | m(B_PCIN) | m(B_READ) | m(B_MDRIN), len);
    push_run(m(B_MDROUT) | m(B_IRIN), len);
    if (op >= 5'd3 && op <= 5'd6) begin
      aop = int'(op) - 3;
      push_run(m(B_GRB) | m(B_ROUT) | m(B_YIN), len);
      push_run(m(B_GRC) | m(B_ROUT) | m(B_ZIN) | alu_w(aop), len);
      push_run(m(B_ZLOWOUT) | m(B_GRA) | m(B_RIN), len);
    end else if (op >= 5'd12 && op <= 5'd14) begin
      aop = (op == 5'd12) ? 0 : int'(op) - 11;
      push_run(m(B_GRB) | m(B_ROUT) | m(B_YIN), len);
      push_run(m(B_COUT) | m(B_ZIN) | alu_w(aop), len);
      push_run(m(B_ZLOWOUT) | m(B_GRA) | m(B_RIN), len);
    end else if (op <= 5'd2) begin
      push_run(m(B_GRB) | m(B_BAOUT) | m(B_YIN), len);
      push_run(m(B_COUT) | m(B_ZIN), len);
      if (op == 5'd1) begin
        push_run(m(B_ZLOWOUT) | m(B_GRA) | m(B_RIN), len);
      end else begin
        push_run(m(B_ZLOWOUT) | m(B_MARIN), len);
        if (op == 5'd0) begin
          push_run(m(B_READ) | m(B_MDRIN), len);
          push_run(m(B_MDROUT) | m(B_GRA) | m(B_RIN), len);
        end else begin
          push_run(m(B_GRA) | m(B_ROUT) | m(B_MDRIN), len);
          push_run(m(B_WRITE), len);
        end
      end
    end else if (op == 5'd18) begin
      push_run(m(B_GRA) | m(B_ROUT) | m(B_CONIN), len);
      push_run(m(B_PCOUT) | m(B_YIN), len);
      push_run(m(B_COUT) | m(B_ZIN), len);
      push_run(m(B_ZLOWOUT) | (con ? m(B_PCIN) : '0), len);
    end else if (op == 5'd20) begin
      push_run(m(B_GRA) | m(B_ROUT) | m(B_PCIN), len);
    end else if (op == 5'd26 || op == 5'd27) begin
      push_run('0, len);
    end else begin
      push_run(m(B_ILLEGAL), len);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1 with the DUT in T0; returns at posedge+1 after the last step
  task automatic do_instr(input string tag, input logic [31:0] instr, input logic con,
                          input int stop_k, input int exp_len);
    int len;
    cur_tag = tag;
    ir      = instr;
    con_ff  = con;
    model_instr(instr, con, len);
    check({tag, " latency"}, len, exp_len);
    for (int k = 0; k < len; k++) begin
      if (k == stop_k) stop = 1'b1;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic hold_halt(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back('0);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_t0(input string tag);
    check({tag, " t0_fetch_lines"}, {PCout, MARin, IncPC, Zin, run}, 5'b11111);
    check({tag, " t0_state"}, o_state, ST_T0);
  endtask

  task automatic reset_pulse(input string tag);
    cur_tag = tag;
    reset_n = 1'b0;
    #1;
    check({tag, " rst_state"}, o_state, ST_RST);
    check({tag, " rst_run"}, run, 1'b0);
    exp_q.push_back('0);
    exp_q.push_back('0);
    @(negedge clock);
    @(negedge clock);
    #2;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check_t0(tag);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_n = 1'b0;
    ir      = '0;
    con_ff  = 1'b0;
    stop    = 1'b0;
    for (int k = 0; k < 3; k++) exp_q.push_back('0);
    repeat (3) @(negedge clock);
    check("reset alu_op", alu_op, 4'd0);
    #2;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check_t0("reset_release");

    do_instr("add",   32'h18918000, 1'b0, -1, 6);
    do_instr("sub",   32'h20918000, 1'b0, -1, 6);
    do_instr("ori",   32'h70900007, 1'b0, -1, 6);
    do_instr("andi",  32'h68900003, 1'b0, -1, 6);
    do_instr("ldi",   32'h08800010, 1'b0, -1, 6);
    do_instr("ld",    32'h01000055, 1'b0, -1, 8);
    do_instr("st",    32'h11000020, 1'b0, -1, 8);
    do_instr("br_t",  32'h92800008, 1'b1, -1, 7);
    do_instr("br_f",  32'h92800008, 1'b0, -1, 7);
    do_instr("jr",    32'hA1000000, 1'b0, -1, 4);
    do_instr("nop",   32'hD0000000, 1'b0, -1, 4);
    do_instr("bad1f", 32'hF8000000, 1'b0, -1, 4);
    do_instr("bad07", 32'h38000000, 1'b0, -1, 4);
    check_t0("after_bad");

    // stop raised during T4 of an add: add finishes, then HALT
    do_instr("add_stop", 32'h18918000, 1'b0, 4, 6);
    hold_halt(5);
    stop = 1'b0;
    hold_halt(3);
    check("add_stop halt_state", o_state, ST_HALT);
    reset_pulse("stop_reset");

    // reset dropped during T6 of st: no Write, straight to RST
    begin
      int len;
      cur_tag = "st_reset";
      ir      = 32'h11000020;
      model_instr(ir, 1'b0, len);
      check("st_reset latency", len, 8);
      void'(exp_q.pop_back());
      void'(exp_q.pop_back());
      repeat (6) begin
        @(posedge clock);
        #1;
      end
      check("st_reset t6_lines", {Gra, Rout, MDRin, Read, Write}, 5'b11100);
      reset_n = 1'b0;
      #1;
      check("st_reset state", o_state, ST_RST);
      check("st_reset write", Write, 1'b0);
      for (int k = 0; k < 3; k++) exp_q.push_back('0);
      repeat (3) @(negedge clock);
      #2;
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      check_t0("st_reset");
    end

    // halt instruction: parked for 20 cycles, leaves only on reset
    do_instr("halt", 32'hD8000000, 1'b0, -1, 4);
    hold_halt(20);
    check("halt run", run, 1'b0);
    check("halt state", o_state, ST_HALT);
    reset_pulse("halt_reset");
    do_instr("nop_after", 32'hD0000000, 1'b0, -1, 4);

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
